// File: rtl/elevator_scheduler_if.sv
// Keypad-to-scheduler bus plus the car status outputs.
// Handshake: 'pressed' is a level from the keypad scanner and 'buttonBus' is
// valid whenever pressed=1. A key is taken exactly once, on the first cycle
// pressed is seen high. The scheduler has no ready signal and never stalls a key.
interface elevator_scheduler_if #(
  parameter int NUM_FLOORS = 8
);
  localparam int FW = $clog2(NUM_FLOORS);

  logic                  pressed;
  logic [3:0]            buttonBus;
  logic [FW-1:0]         floor;
  logic [NUM_FLOORS-1:0] req_pending;
  logic                  moving;
  logic                  dir_up;
  logic                  door_open;
  logic                  arrive;
  logic [1:0]            fsm_state;

  modport master (
    output pressed, buttonBus,
    input  floor, req_pending, moving, dir_up, door_open, arrive, fsm_state
  );

  modport slave (
    input  pressed, buttonBus,
    output floor, req_pending, moving, dir_up, door_open, arrive, fsm_state
  );
endinterface

// File: rtl/elevator_scheduler.sv
// Elevator request scheduler and car sequencer.
// Latches floor calls into a pending bitmap and runs the car through
// IDLE/MOVE/DOOR with collective ordering: keep going the current way while
// calls remain ahead, otherwise turn around. Floor travel and door dwell are
// timed with a shared tick counter. fsm_state exposes the FSM for debug.
module elevator_scheduler #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_TICKS = 1000,
  parameter int DOOR_TICKS  = 2000,
  parameter int TIMER_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  elevator_scheduler_if.slave  bus
);
  localparam int FW = $clog2(NUM_FLOORS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t                state;
  logic [FW-1:0]         floor_q;
  logic [NUM_FLOORS-1:0] req_q;
  logic                  dir_q;
  logic                  moving_q;
  logic                  door_q;
  logic                  arrive_q;
  logic [TIMER_W-1:0]    timer_q;
  logic                  pressed_q;

  // One-hot of a key code; codes outside the floor range give all zeros.
  function automatic logic [NUM_FLOORS-1:0] onehot(input logic [3:0] c);
    logic [NUM_FLOORS-1:0] r;
    for (int i = 0; i < NUM_FLOORS; i++) r[i] = (c == 4'(i));
    return r;
  endfunction

  // Any pending call strictly above (up=1) or strictly below (up=0) floor f.
  function automatic logic any_dir(input logic [NUM_FLOORS-1:0] p,
                                   input logic [FW-1:0] f, input logic up);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (p[i] && (up ? (FW'(i) > f) : (FW'(i) < f))) r = 1'b1;
    end
    return r;
  endfunction

  logic                  accept;
  logic [3:0]            code;
  logic                  at_here;
  logic                  hold;
  logic                  cancel;
  logic [NUM_FLOORS-1:0] code_oh;
  logic [NUM_FLOORS-1:0] here_oh;
  logic [NUM_FLOORS-1:0] next_oh;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] pend_n;
  logic [NUM_FLOORS-1:0] door_pend;
  logic [FW-1:0]         next_floor;
  logic                  ahead_idle;
  logic                  behind_idle;
  logic                  ahead_door;
  logic                  behind_door;
  logic                  ahead_arrive;
  logic                  floor_done;
  logic                  door_done;

  // Key decode and look-ahead/behind terms for the FSM.
  always_comb begin
    accept     = bus.pressed & ~pressed_q;
    code       = bus.buttonBus;
    code_oh    = onehot(code);
    here_oh    = onehot(4'(floor_q));
    at_here    = accept && (code == 4'(floor_q));
    hold       = accept && (code == 4'hE);
    cancel     = accept && (code == 4'hF);
    // A call for the current floor only latches while travelling away from it.
    set_mask   = '0;
    if (accept) set_mask = code_oh & ((state == MOVE) ? '1 : ~here_oh);
    pend_n     = cancel ? '0 : (req_q | set_mask);
    door_pend  = pend_n & ~here_oh;
    next_floor = dir_q ? (floor_q + FW'(1)) : (floor_q - FW'(1));
    next_oh    = onehot(4'(next_floor));
    ahead_idle   = any_dir(req_q, floor_q, dir_q);
    behind_idle  = any_dir(req_q, floor_q, ~dir_q);
    ahead_door   = any_dir(door_pend, floor_q, dir_q);
    behind_door  = any_dir(door_pend, floor_q, ~dir_q);
    ahead_arrive = any_dir(pend_n, next_floor, dir_q);
    floor_done   = (timer_q == TIMER_W'(FLOOR_TICKS - 1));
    door_done    = (timer_q == TIMER_W'(DOOR_TICKS - 1));
  end

  // Car sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      floor_q   <= '0;
      req_q     <= '0;
      dir_q     <= 1'b1;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
      arrive_q  <= 1'b0;
      timer_q   <= '0;
      pressed_q <= 1'b0;
    end else begin
      pressed_q <= bus.pressed;
      arrive_q  <= 1'b0;
      case (state)
        IDLE: begin
          req_q   <= pend_n;
          timer_q <= '0;
          if (at_here || hold) begin
            state  <= DOOR;
            door_q <= 1'b1;
          end else if (ahead_idle) begin
            state    <= MOVE;
            moving_q <= 1'b1;
          end else if (behind_idle) begin
            state    <= MOVE;
            moving_q <= 1'b1;
            dir_q    <= ~dir_q;
          end
        end
        MOVE: begin
          if (floor_done) begin
            timer_q  <= '0;
            floor_q  <= next_floor;
            arrive_q <= 1'b1;
            if (|(pend_n & next_oh)) begin
              // Servicing the new floor wins over a call for it set this cycle.
              state    <= DOOR;
              moving_q <= 1'b0;
              door_q   <= 1'b1;
              req_q    <= pend_n & ~next_oh;
            end else begin
              req_q <= pend_n;
              if (!ahead_arrive) begin
                state    <= IDLE;
                moving_q <= 1'b0;
              end
            end
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
            req_q   <= pend_n;
          end
        end
        DOOR: begin
          req_q <= door_pend;
          if (at_here || hold) begin
            timer_q <= '0;
          end else if (door_done) begin
            timer_q <= '0;
            door_q  <= 1'b0;
            if (ahead_door) begin
              state    <= MOVE;
              moving_q <= 1'b1;
            end else if (behind_door) begin
              state    <= MOVE;
              moving_q <= 1'b1;
              dir_q    <= ~dir_q;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.floor       = floor_q;
  assign bus.req_pending = req_q;
  assign bus.moving      = moving_q;
  assign bus.dir_up      = dir_q;
  assign bus.door_open   = door_q;
  assign bus.arrive      = arrive_q;
  assign bus.fsm_state   = state;
endmodule
